// File: rtl/tpu_drain_pkg.sv
// Shared types, constants and the per-lane requantizer for the result drain.
package tpu_drain_pkg;

  localparam int ADDRESSSIZE    = 10;
  localparam int MATRIX_SIZE    = 64;
  localparam int PARTIAL_SUM_BW = 24;
  localparam int DATA_BW        = 8;
  localparam int SHIFT_BW       = 5;
  localparam int FIFO_DEPTH     = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_FLUSH
  } drain_state_e;

  localparam logic signed [PARTIAL_SUM_BW:0] SAT_MAX =
    (PARTIAL_SUM_BW+1)'(2**(DATA_BW-1) - 1);
  localparam logic signed [PARTIAL_SUM_BW:0] SAT_MIN =
    -$signed((PARTIAL_SUM_BW+1)'(2**(DATA_BW-1)));

  // One extra bit of headroom keeps the round-half-up add from overflowing.
  function automatic logic [DATA_BW-1:0] requant_lane(
    input logic [PARTIAL_SUM_BW-1:0] value,
    input logic [SHIFT_BW-1:0]       shift,
    input logic                      relu_en
  );
    logic signed [PARTIAL_SUM_BW:0] acc;
    logic signed [PARTIAL_SUM_BW:0] rnd;
    acc = $signed({value[PARTIAL_SUM_BW-1], value});
    rnd = '0;
    if (relu_en && acc[PARTIAL_SUM_BW]) acc = '0;
    if (shift != '0) begin
      rnd = $signed((PARTIAL_SUM_BW+1)'(1) << (shift - SHIFT_BW'(1)));
      acc = (acc + rnd) >>> shift;
    end
    if (acc > SAT_MAX)      requant_lane = SAT_MAX[DATA_BW-1:0];
    else if (acc < SAT_MIN) requant_lane = SAT_MIN[DATA_BW-1:0];
    else                    requant_lane = acc[DATA_BW-1:0];
  endfunction

endpackage

// File: rtl/tpu_result_drain_fifo.sv
// Two-entry FIFO holding {last, row} between the SRAM read and the consumer.
module drain_fifo2
  import tpu_drain_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign full    = (count == 2'(FIFO_DEPTH));
  assign empty   = (count == 2'd0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tpu_result_drain.sv
// Drains result rows from the results SRAM, requantizes each lane and streams
// them out one row per valid/ready transfer.
module tpu_result_drain
  import tpu_drain_pkg::*;
#(
  parameter int ADDRESSSIZE    = tpu_drain_pkg::ADDRESSSIZE,
  parameter int MATRIX_SIZE    = tpu_drain_pkg::MATRIX_SIZE,
  parameter int PARTIAL_SUM_BW = tpu_drain_pkg::PARTIAL_SUM_BW,
  parameter int DATA_BW        = tpu_drain_pkg::DATA_BW,
  parameter int SHIFT_BW       = tpu_drain_pkg::SHIFT_BW
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ADDRESSSIZE-1:0]            base_addr,
  input  logic [ADDRESSSIZE-1:0]            row_count,
  input  logic [SHIFT_BW-1:0]               shift,
  input  logic                              relu_en,
  output logic                              rd_en,
  output logic [ADDRESSSIZE-1:0]            rd_addr,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] rd_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_BW*MATRIX_SIZE-1:0]    out_data,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done
);

  localparam int OUT_W = DATA_BW * MATRIX_SIZE;

  drain_state_e           state;
  drain_state_e           state_next;
  logic [ADDRESSSIZE-1:0] base_q;
  logic [ADDRESSSIZE-1:0] rows_q;
  logic [ADDRESSSIZE-1:0] issue_cnt;
  logic [ADDRESSSIZE-1:0] hs_cnt;
  logic [SHIFT_BW-1:0]    shift_q;
  logic                   relu_q;
  logic                   inflight;
  logic                   inflight_last;
  logic                   done_q;
  logic                   start_ok;
  logic                   issue;
  logic                   last_issue;
  logic                   last_hs;
  logic                   pop;
  logic [2:0]             credit_used;
  logic [OUT_W-1:0]       req_row;
  logic [OUT_W:0]         head;
  logic [1:0]             fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  // A row transfers when out_valid && out_ready; the head entry (data and
  // last) is held unchanged while out_valid is high and out_ready is low.
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = head[OUT_W-1:0];
  assign out_last  = out_valid && head[OUT_W];

  // Credits count buffered rows plus the read in flight; the row leaving this
  // cycle frees its slot immediately so a steady stream sustains 1 row/cycle.
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = (state == ST_READ) && !(fifo_full && !pop)
                       && (credit_used < 3'(FIFO_DEPTH));
  assign last_issue  = issue && (issue_cnt == rows_q - ADDRESSSIZE'(1));
  assign last_hs     = pop && (hs_cnt == rows_q - ADDRESSSIZE'(1));

  assign rd_en   = issue;
  assign rd_addr = issue ? base_q + issue_cnt : '0;
  assign busy    = (state != ST_IDLE);
  assign done    = done_q;

  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          if (row_count != '0) state_next = ST_READ;
        end
      end
      ST_READ:  if (last_issue) state_next = ST_FLUSH;
      ST_FLUSH: if (last_hs)    state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      base_q        <= '0;
      rows_q        <= '0;
      shift_q       <= '0;
      relu_q        <= 1'b0;
      issue_cnt     <= '0;
      hs_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state         <= state_next;
      inflight      <= issue;
      inflight_last <= last_issue;
      done_q        <= (start_ok && (row_count == '0)) || ((state == ST_FLUSH) && last_hs);
      if (start_ok) begin
        base_q    <= base_addr;
        rows_q    <= row_count;
        shift_q   <= shift;
        relu_q    <= relu_en;
        issue_cnt <= '0;
        hs_cnt    <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + ADDRESSSIZE'(1);
        if (pop)   hs_cnt    <= hs_cnt + ADDRESSSIZE'(1);
      end
    end
  end

  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    assign req_row[i*DATA_BW +: DATA_BW] =
      requant_lane(rd_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW], shift_q, relu_q);
  end

  drain_fifo2 #(.W(OUT_W + 1)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .wdata ({inflight_last, req_row}),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_tpu_result_drain.sv
// Self-checking bench for tpu_result_drain: SRAM model, row-level reference
// model with expected queues, directed and randomized passes.
module tb_tpu_result_drain;

  localparam int AW    = 10;
  localparam int MS    = 64;
  localparam int PSB   = 24;
  localparam int DBW   = 8;
  localparam int SBW   = 5;
  localparam int ROW_W = PSB * MS;
  localparam int OUT_W = DBW * MS;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW-1:0]     row_count;
  logic [SBW-1:0]    shift;
  logic              relu_en;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [ROW_W-1:0]  rd_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  tpu_result_drain dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .row_count (row_count),
    .shift     (shift),
    .relu_en   (relu_en),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  logic [ROW_W-1:0] mem [0:1023];

  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : {48{32'hdead_beef}};

  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 99) < 30);
      default: out_ready = 1'b0;
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference requantization in plain integer arithmetic with floor division.
  function automatic logic [DBW-1:0] ref_lane(input int v, input int sh, input bit relu);
    longint x, d, q;
    x = v;
    if (relu && x < 0) x = 0;
    if (sh > 0) begin
      d = longint'(1) << sh;
      x = x + d / 2;
      q = x / d;
      if (x < 0 && (x % d) != 0) q = q - 1;
      x = q;
    end
    if (x > 127)  x = 127;
    if (x < -128) x = -128;
    return x[DBW-1:0];
  endfunction

  // Scoreboard state
  logic [OUT_W-1:0] exp_q[$];
  logic             exp_last_q[$];
  logic [AW-1:0]    exp_addr_q[$];
  bit               model_busy = 0;
  bit               done_due   = 0;
  bit               prev_stall = 0;
  logic [OUT_W-1:0] prev_data;
  logic             prev_last;
  int               issued = 0;
  int               popped = 0;
  int               hs_total = 0;
  logic [AW-1:0]    m_addr;
  logic [OUT_W-1:0] m_row;
  bit               was_busy;
  logic             m_last;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_last_q.delete();
      exp_addr_q.delete();
      model_busy = 0;
      done_due   = 0;
      prev_stall = 0;
    end else begin
      was_busy = model_busy;
      check("busy", busy, model_busy);
      check("done", done, done_due);
      done_due = 0;
      if (rd_en) begin
        issued++;
        if (exp_addr_q.size() == 0) check("rd_en_unexpected", rd_en, 0);
        else check("rd_addr", rd_addr, exp_addr_q.pop_front());
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        popped++;
        hs_total++;
        if (exp_q.size() == 0) check("row_unexpected", out_valid, 0);
        else begin
          check("row_data", out_data, exp_q.pop_front());
          m_last = exp_last_q.pop_front();
          check("row_last", out_last, m_last);
          if (m_last) begin
            model_busy = 0;
            done_due   = 1;
          end
        end
      end
      if (rd_en) check("outstanding", (issued - popped) <= 2, 1);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (start && !was_busy) begin
        if (row_count == '0) done_due = 1;
        else begin
          model_busy = 1;
          issued = 0;
          popped = 0;
          for (int r = 0; r < int'(row_count); r++) begin
            m_addr = AW'(int'(base_addr) + r);
            exp_addr_q.push_back(m_addr);
            for (int l = 0; l < MS; l++)
              m_row[l*DBW +: DBW] = ref_lane(int'($signed(mem[m_addr][l*PSB +: PSB])),
                                             int'(shift), relu_en);
            exp_q.push_back(m_row);
            exp_last_q.push_back(r == int'(row_count) - 1);
          end
        end
      end
    end
  end

  int pat0[3] = '{-5, 100, 127};
  int pat1[6] = '{1000, -1000, 383, -384, 8388607, -8388608};

  task automatic fill(input int b, input int n, input int mode);
    logic [AW-1:0] a;
    int v, w;
    for (int r = 0; r < n; r++) begin
      a = AW'(b + r);
      for (int l = 0; l < MS; l++) begin
        if (mode == 0)      v = pat0[l % 3];
        else if (mode == 1) v = pat1[l % 6];
        else begin
          w = $urandom_range(4, PSB);
          v = int'($urandom);
          v = (v <<< (32 - w)) >>> (32 - w);
        end
        mem[a][l*PSB +: PSB] = PSB'(v);
      end
    end
  endtask

  task automatic launch(input int b, input int rc, input int sh, input bit relu);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(b); row_count = AW'(rc); shift = SBW'(sh); relu_en = relu;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int exp_lat);
    int lat;
    bit seen;
    seen = 0;
    for (lat = 1; lat <= budget; lat++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("done_seen", seen, 1);
    if (seen && exp_lat > 0) check("latency", lat, exp_lat);
    check("rows_left", exp_q.size(), 0);
    check("reads_left", exp_addr_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int hs_target;
    int b, rc;
    rst = 1'b1; start = 1'b0; base_addr = '0; row_count = '0; shift = '0; relu_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Basic pass at full throughput: 64 rows, done 67 cycles after start edge.
    fill(0, 64, 0);
    ready_mode = 0;
    launch(0, 64, 0, 0);
    wait_done(200, 67);

    // Requantization corners with and without ReLU, then unshifted saturation.
    fill(100, 4, 1);
    launch(100, 4, 3, 0);
    wait_done(50, 7);
    launch(100, 4, 3, 1);
    wait_done(50, 7);
    launch(100, 4, 0, 0);
    wait_done(50, 7);

    // Randomized passes under random backpressure.
    ready_mode = 1;
    for (int k = 0; k < 4; k++) begin
      b  = $urandom_range(0, 1023);
      rc = $urandom_range(1, 20);
      fill(b, rc, 2);
      launch(b, rc, $urandom_range(0, 12), 1'($urandom_range(0, 1)));
      wait_done(2000, -1);
    end

    // Long stall mid-pass, with an ignored start while busy.
    fill(300, 30, 2);
    launch(300, 30, 4, 0);
    repeat (8) @(posedge clk);
    #1 ready_mode = 2;
    launch(700, 5, 1, 1);
    repeat (10) @(posedge clk);
    #1 ready_mode = 1;
    wait_done(2000, -1);

    // Address wrap and empty pass.
    ready_mode = 0;
    fill(1020, 8, 2);
    launch(1020, 8, 2, 0);
    wait_done(50, 11);
    launch(5, 0, 0, 0);
    wait_done(10, 1);

    // Reset mid-pass aborts silently; the next pass drains from base_addr.
    fill(200, 40, 2);
    hs_target = hs_total + 10;
    launch(200, 40, 5, 0);
    for (int i = 0; i < 200 && hs_total < hs_target; i++) @(negedge clk);
    check("hs_before_reset", hs_total >= hs_target, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    launch(200, 40, 5, 1);
    wait_done(100, 43);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
